// File: rtl/frac_interp_gen2.sv
// Fractional position generator for the scandoubler/scaler path.
// Serial restoring divider derives the step increment and output span; step logic walks the source.
module frac_interp_gen2 #(
  parameter int BITWIDTH  = 12,
  parameter int FRACWIDTH = 16,
  parameter int ADVWIDTH  = 4
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic [BITWIDTH-1:0]  num,
  input  logic [BITWIDTH-1:0]  den,
  input  logic [BITWIDTH-1:0]  limit,
  input  logic                 newfraction,
  output logic                 ready,
  output logic [BITWIDTH-1:0]  limit_out,
  input  logic                 interp_mode,
  input  logic                 step_reset,
  input  logic                 step_in,
  input  logic [FRACWIDTH-1:0] phase_offset,
  input  logic [BITWIDTH-1:0]  pan_offset,
  input  logic [BITWIDTH-1:0]  centre_offset,
  output logic                 pix_valid,
  output logic [BITWIDTH-1:0]  whole,
  output logic [FRACWIDTH-1:0] fraction,
  output logic [ADVWIDTH-1:0]  adv,
  output logic                 blank
);

  // state   | meaning
  // IDLE    | no fraction programmed since reset
  // DIV_INC | dividing (den << FRACWIDTH) by num
  // DIV_LIM | dividing limit*num by den
  // DONE    | inc and limit_out valid, stepping allowed
  localparam logic [1:0] IDLE    = 2'd0;
  localparam logic [1:0] DIV_INC = 2'd1;
  localparam logic [1:0] DIV_LIM = 2'd2;
  localparam logic [1:0] DONE    = 2'd3;

  localparam int DW = 2*BITWIDTH + FRACWIDTH;
  localparam int AW = BITWIDTH + FRACWIDTH;
  localparam int CW = $clog2(DW + 1);

  logic [1:0]          state;
  logic [CW-1:0]       cnt;
  logic [BITWIDTH-1:0] num_r, den_r, limit_r, divisor, rem;
  logic                zero_r;
  logic [DW-1:0]       quo;
  logic [AW-1:0]       inc, acc;
  logic [BITWIDTH-1:0] border, prev_whole;

  logic [BITWIDTH:0]     rem_sh, rem_sub;
  logic                  q_bit;
  logic [BITWIDTH-1:0]   rem_nx;
  logic [DW-1:0]         quo_nx;
  logic [AW-1:0]         inc_sat;
  logic [BITWIDTH-1:0]   lim_sat;
  logic [2*BITWIDTH-1:0] prod;
  logic [DW-1:0]         lim_dividend;

  // Remainder stays below the divisor, so BITWIDTH+1 bits hold every trial subtraction.
  assign rem_sh       = {rem, quo[DW-1]};
  assign rem_sub      = rem_sh - {1'b0, divisor};
  assign q_bit        = ~rem_sub[BITWIDTH];
  assign rem_nx       = q_bit ? rem_sub[BITWIDTH-1:0] : rem_sh[BITWIDTH-1:0];
  assign quo_nx       = {quo[DW-2:0], q_bit};
  assign inc_sat      = (|quo_nx[DW-1:AW]) ? {AW{1'b1}} : quo_nx[AW-1:0];
  assign lim_sat      = (|quo_nx[DW-1:BITWIDTH]) ? {BITWIDTH{1'b1}} : quo_nx[BITWIDTH-1:0];
  assign prod         = {{BITWIDTH{1'b0}}, limit_r} * {{BITWIDTH{1'b0}}, num_r};
  assign lim_dividend = {{FRACWIDTH{1'b0}}, prod};
  assign ready        = (state == DONE);

  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= IDLE;
      cnt       <= '0;
      num_r     <= '0;
      den_r     <= '0;
      limit_r   <= '0;
      zero_r    <= 1'b0;
      divisor   <= '0;
      rem       <= '0;
      quo       <= '0;
      inc       <= '0;
      limit_out <= '0;
    end else if (newfraction) begin
      num_r   <= num;
      den_r   <= den;
      limit_r <= limit;
      zero_r  <= (num == '0) || (den == '0);
      quo     <= {{BITWIDTH{1'b0}}, den, {FRACWIDTH{1'b0}}};
      rem     <= '0;
      divisor <= num;
      cnt     <= CW'(DW - 1);
      state   <= DIV_INC;
    end else begin
      case (state)
        DIV_INC: begin
          if (zero_r) begin
            inc       <= '0;
            limit_out <= '0;
            state     <= DONE;
          end else if (cnt == '0) begin
            inc     <= inc_sat;
            quo     <= lim_dividend;
            rem     <= '0;
            divisor <= den_r;
            cnt     <= CW'(DW - 1);
            state   <= DIV_LIM;
          end else begin
            quo <= quo_nx;
            rem <= rem_nx;
            cnt <= cnt - 1'b1;
          end
        end
        DIV_LIM: begin
          quo <= quo_nx;
          rem <= rem_nx;
          if (cnt == '0) begin
            limit_out <= lim_sat;
            state     <= DONE;
          end else begin
            cnt <= cnt - 1'b1;
          end
        end
        default: state <= state;
      endcase
    end
  end

  logic [BITWIDTH-1:0]  acc_whole, wh_r, diff;
  logic [FRACWIDTH-1:0] acc_frac, fr_o;
  logic [ADVWIDTH-1:0]  adv_sat;
  logic                 accept;

  assign acc_whole = acc[AW-1:FRACWIDTH];
  assign acc_frac  = acc[FRACWIDTH-1:0];
  assign wh_r      = acc_whole + BITWIDTH'(interp_mode & acc_frac[FRACWIDTH-1]);
  assign fr_o      = interp_mode ? '0 : acc_frac;
  assign diff      = wh_r - prev_whole;
  assign adv_sat   = (|diff[BITWIDTH-1:ADVWIDTH]) ? {ADVWIDTH{1'b1}} : diff[ADVWIDTH-1:0];
  assign accept    = step_in & ready & ~step_reset & ~newfraction;

  always_ff @(posedge clk) begin
    if (reset) begin
      acc        <= '0;
      border     <= '0;
      prev_whole <= '0;
      pix_valid  <= 1'b0;
      whole      <= '0;
      fraction   <= '0;
      adv        <= '0;
      blank      <= 1'b1;
    end else begin
      pix_valid <= 1'b0;
      if (step_reset && !newfraction) begin
        acc        <= {pan_offset, phase_offset};
        border     <= centre_offset;
        prev_whole <= pan_offset;
      end else if (accept) begin
        pix_valid <= 1'b1;
        if (border != '0) begin
          border   <= border - 1'b1;
          whole    <= acc_whole;
          fraction <= '0;
          adv      <= '0;
          blank    <= 1'b1;
        end else begin
          whole      <= wh_r;
          fraction   <= fr_o;
          adv        <= adv_sat;
          prev_whole <= wh_r;
          acc        <= acc + inc;
          blank      <= zero_r || (wh_r >= limit_r);
        end
      end
    end
  end

endmodule

// File: tb/tb_frac_interp_gen2.sv
// Bench for frac_interp_gen2: fixed vector table, hand-written corner sequences,
// and randomized configurations checked against an arithmetic reference model.
module tb_frac_interp_gen2;

  logic        clk = 1'b0;
  logic        reset, newfraction, interp_mode, step_reset, step_in;
  logic [11:0] num, den, limit, pan_offset, centre_offset;
  logic [15:0] phase_offset;
  logic        ready, pix_valid, blank;
  logic [11:0] limit_out, whole;
  logic [15:0] fraction;
  logic [3:0]  adv;

  frac_interp_gen2 #(.BITWIDTH(12), .FRACWIDTH(16), .ADVWIDTH(4)) dut (
    .clk(clk), .reset(reset), .num(num), .den(den), .limit(limit),
    .newfraction(newfraction), .ready(ready), .limit_out(limit_out),
    .interp_mode(interp_mode), .step_reset(step_reset), .step_in(step_in),
    .phase_offset(phase_offset), .pan_offset(pan_offset), .centre_offset(centre_offset),
    .pix_valid(pix_valid), .whole(whole), .fraction(fraction), .adv(adv), .blank(blank)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Reference model: positions as plain integers, 16 fractional bits.
  longint m_inc, m_lim, m_acc, m_border, m_prev, m_limit;
  bit     m_zero;

  task automatic model_cfg(input longint n, input longint d, input longint l);
    m_limit = l;
    m_zero  = (n == 0) || (d == 0);
    if (m_zero) begin
      m_inc = 0;
      m_lim = 0;
    end else begin
      m_inc = (d * 65536) / n;
      if (m_inc > 64'h0FFF_FFFF) m_inc = 64'h0FFF_FFFF;
      m_lim = (l * n) / d;
      if (m_lim > 4095) m_lim = 4095;
    end
  endtask

  task automatic model_sreset(input longint p, input longint ph, input longint c);
    m_acc    = p * 65536 + ph;
    m_border = c;
    m_prev   = p;
  endtask

  task automatic model_step(input bit mode, output logic [11:0] w, output logic [15:0] f,
                            output logic [3:0] a, output logic b);
    longint wi, fi, d;
    if (m_border > 0) begin
      m_border--;
      w = 12'(m_acc / 65536);
      f = '0;
      a = '0;
      b = 1'b1;
    end else begin
      wi = m_acc / 65536;
      fi = m_acc % 65536;
      if (mode) begin
        if (fi >= 32768) wi = (wi + 1) % 4096;
        fi = 0;
      end
      d = (wi - m_prev + 4096) % 4096;
      if (d > 15) d = 15;
      m_prev = wi;
      m_acc  = (m_acc + m_inc) % (64'd1 << 28);
      w = 12'(wi);
      f = 16'(fi);
      a = 4'(d);
      b = m_zero || (wi >= m_limit);
    end
  endtask

  task automatic configure(input logic [11:0] n, input logic [11:0] d, input logic [11:0] l,
                           output int cyc);
    @(negedge clk);
    num = n; den = d; limit = l; newfraction = 1'b1;
    model_cfg(n, d, l);
    @(negedge clk);
    newfraction = 1'b0;
    cyc = 1;
    while (!ready && cyc < 200) begin
      @(negedge clk);
      cyc++;
    end
  endtask

  task automatic sreset(input logic [11:0] p, input logic [15:0] ph, input logic [11:0] c);
    @(negedge clk);
    pan_offset = p; phase_offset = ph; centre_offset = c; step_reset = 1'b1;
    model_sreset(p, ph, c);
    @(negedge clk);
    step_reset = 1'b0;
  endtask

  typedef struct packed {
    logic [11:0]       num, den, limit;
    logic              mode;
    logic [11:0]       pan;
    logic [15:0]       phase;
    logic [11:0]       centre;
    logic [6:0]        rdy;
    logic [11:0]       lim;
    logic [4:0][11:0]  w;
    logic [4:0][15:0]  f;
    logic [4:0][3:0]   a;
    logic [4:0]        b;
  } vec_t;

  function automatic vec_t mk(input logic [11:0] n, d, l, input logic m, input logic [11:0] p,
                              input logic [15:0] ph, input logic [11:0] c, input logic [6:0] r,
                              input logic [11:0] lo, input logic [59:0] w, input logic [79:0] f,
                              input logic [19:0] a, input logic [4:0] b);
    vec_t v;
    v.num = n; v.den = d; v.limit = l; v.mode = m; v.pan = p; v.phase = ph; v.centre = c;
    v.rdy = r; v.lim = lo; v.w = w; v.f = f; v.a = a; v.b = b;
    return v;
  endfunction

  localparam int NV = 8;
  vec_t tv [NV];

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int cyc, pv_seen, rdy_seen;
    logic [11:0] ew;
    logic [15:0] ef;
    logic [3:0]  ea;
    logic        eb, epv, rmode;
    logic [11:0] rn, rd, rl;

    // Per-pixel lists are written last pixel first.
    tv[0] = mk(320, 160, 100, 0, 0, 0, 0, 81, 200, {12'd2,12'd1,12'd1,12'd0,12'd0},
               {16'h0,16'h8000,16'h0,16'h8000,16'h0}, {4'd1,4'd0,4'd1,4'd0,4'd0}, 5'b00000);
    tv[1] = mk(160, 320, 320, 0, 0, 0, 0, 81, 160, {12'd8,12'd6,12'd4,12'd2,12'd0},
               80'h0, {4'd2,4'd2,4'd2,4'd2,4'd0}, 5'b00000);
    tv[2] = mk(320, 160, 100, 1, 0, 0, 0, 81, 200, {12'd2,12'd2,12'd1,12'd1,12'd0},
               80'h0, {4'd0,4'd1,4'd0,4'd1,4'd0}, 5'b00000);
    tv[3] = mk(320, 160, 100, 0, 0, 0, 3, 81, 200, 60'h0,
               {16'h8000,16'h0,16'h0,16'h0,16'h0}, 20'h0, 5'b00111);
    tv[4] = mk(320, 160, 2, 0, 1, 0, 0, 81, 4, {12'd3,12'd2,12'd2,12'd1,12'd1},
               {16'h0,16'h8000,16'h0,16'h8000,16'h0}, {4'd1,4'd0,4'd1,4'd0,4'd0}, 5'b11100);
    tv[5] = mk(0, 160, 100, 0, 5, 0, 0, 2, 0, {12'd5,12'd5,12'd5,12'd5,12'd5},
               80'h0, 20'h0, 5'b11111);
    tv[6] = mk(1, 40, 4095, 0, 0, 0, 0, 81, 102, {12'd160,12'd120,12'd80,12'd40,12'd0},
               80'h0, {4'd15,4'd15,4'd15,4'd15,4'd0}, 5'b00000);
    tv[7] = mk(4095, 1, 4095, 0, 0, 0, 0, 81, 4095, 60'h0,
               {16'd64,16'd48,16'd32,16'd16,16'd0}, 20'h0, 5'b00000);

    reset = 1'b1; newfraction = 1'b0; interp_mode = 1'b0; step_reset = 1'b0; step_in = 1'b0;
    num = '0; den = '0; limit = '0; pan_offset = '0; centre_offset = '0; phase_offset = '0;
    repeat (3) @(negedge clk);
    reset = 1'b0;

    chk("rst_ready", ready, 0);
    chk("rst_pix_valid", pix_valid, 0);
    chk("rst_whole", whole, 0);
    chk("rst_fraction", fraction, 0);
    chk("rst_adv", adv, 0);
    chk("rst_blank", blank, 1);
    chk("rst_limit_out", limit_out, 0);
    step_in = 1'b1;
    @(negedge clk);
    step_in = 1'b0;
    chk("rst_step_ignored", pix_valid, 0);

    for (int i = 0; i < NV; i++) begin
      interp_mode = tv[i].mode;
      configure(tv[i].num, tv[i].den, tv[i].limit, cyc);
      chk($sformatf("v%0d_ready_cycle", i), cyc, tv[i].rdy);
      chk($sformatf("v%0d_limit_out", i), limit_out, tv[i].lim);
      sreset(tv[i].pan, tv[i].phase, tv[i].centre);
      for (int k = 0; k < 5; k++) begin
        step_in = 1'b1;
        @(negedge clk);
        step_in = 1'b0;
        chk($sformatf("v%0d_p%0d_pix_valid", i, k), pix_valid, 1);
        chk($sformatf("v%0d_p%0d_whole", i, k), whole, tv[i].w[k]);
        chk($sformatf("v%0d_p%0d_fraction", i, k), fraction, tv[i].f[k]);
        chk($sformatf("v%0d_p%0d_adv", i, k), adv, tv[i].a[k]);
        chk($sformatf("v%0d_p%0d_blank", i, k), blank, tv[i].b[k]);
        @(negedge clk);
        chk($sformatf("v%0d_p%0d_gap_pv", i, k), pix_valid, 0);
        chk($sformatf("v%0d_p%0d_hold", i, k), whole, tv[i].w[k]);
      end
    end
    interp_mode = 1'b0;

    // Restart mid-divide; step requests during the computation must be ignored.
    @(negedge clk);
    num = 320; den = 160; limit = 100; newfraction = 1'b1;
    @(negedge clk);
    newfraction = 1'b0;
    repeat (29) @(negedge clk);
    chk("restart_pre_ready", ready, 0);
    num = 160; den = 320; limit = 320; newfraction = 1'b1;
    model_cfg(160, 320, 320);
    @(negedge clk);
    newfraction = 1'b0;
    step_in = 1'b1;
    cyc = 1;
    pv_seen = 0;
    while (!ready && cyc < 200) begin
      if (pix_valid) pv_seen++;
      @(negedge clk);
      cyc++;
    end
    step_in = 1'b0;
    chk("restart_no_pix_valid", pv_seen, 0);
    chk("restart_ready_cycle", cyc, 81);
    chk("restart_limit_out", limit_out, 160);

    // step_in coinciding with step_reset is dropped.
    @(negedge clk);
    pan_offset = 7; phase_offset = 16'h4000; centre_offset = 0;
    step_reset = 1'b1; step_in = 1'b1;
    model_sreset(7, 16'h4000, 0);
    @(negedge clk);
    step_reset = 1'b0; step_in = 1'b0;
    chk("sreset_step_dropped", pix_valid, 0);
    step_in = 1'b1;
    model_step(1'b0, ew, ef, ea, eb);
    @(negedge clk);
    step_in = 1'b0;
    chk("sreset_after_pv", pix_valid, 1);
    chk("sreset_after_whole", whole, ew);
    chk("sreset_after_fraction", fraction, ef);

    for (int r = 0; r < 25; r++) begin
      rn = ($urandom_range(0, 9) == 0) ? 12'd0 : 12'($urandom_range(1, 4095));
      rd = ($urandom_range(0, 9) == 0) ? 12'd0 : 12'($urandom_range(1, 4095));
      rl = 12'($urandom_range(0, 4095));
      rmode = 1'($urandom_range(0, 1));
      interp_mode = rmode;
      configure(rn, rd, rl, cyc);
      chk($sformatf("rnd%0d_ready_cycle", r), cyc, m_zero ? 2 : 81);
      chk($sformatf("rnd%0d_limit_out", r), limit_out, m_lim);
      sreset(12'($urandom_range(0, 4095)), 16'($urandom), 12'($urandom_range(0, 4)));
      for (int c = 0; c < 30; c++) begin
        step_in = 1'($urandom_range(0, 1));
        epv = step_in;
        if (epv) model_step(rmode, ew, ef, ea, eb);
        @(negedge clk);
        chk($sformatf("rnd%0d_c%0d_pv", r, c), pix_valid, epv);
        if (epv) begin
          chk($sformatf("rnd%0d_c%0d_whole", r, c), whole, ew);
          chk($sformatf("rnd%0d_c%0d_fraction", r, c), fraction, ef);
          chk($sformatf("rnd%0d_c%0d_adv", r, c), adv, ea);
          chk($sformatf("rnd%0d_c%0d_blank", r, c), blank, eb);
        end
      end
      step_in = 1'b0;
    end
    interp_mode = 1'b0;

    // Reset during DIV_LIM returns to IDLE, which never completes on its own.
    @(negedge clk);
    num = 320; den = 160; limit = 100; newfraction = 1'b1;
    @(negedge clk);
    newfraction = 1'b0;
    repeat (49) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    chk("rst_divlim_ready", ready, 0);
    chk("rst_divlim_blank", blank, 1);
    chk("rst_divlim_pix_valid", pix_valid, 0);
    chk("rst_divlim_limit_out", limit_out, 0);
    step_in = 1'b1;
    pv_seen = 0;
    rdy_seen = 0;
    repeat (100) begin
      @(negedge clk);
      if (pix_valid) pv_seen++;
      if (ready) rdy_seen++;
    end
    step_in = 1'b0;
    chk("idle_no_ready", rdy_seen, 0);
    chk("idle_no_pix_valid", pv_seen, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
